cmd_decoder: RTL and testbench
==============================

CMD_DECODER -- requirements
Module: cmd_decoder

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the received byte and of the register-file write data.
REQ-002 Parameter ADDR_WIDTH, default 4: width of the register-file address.
REQ-003 CLK  input  1: single clock, the destination-domain clock of the bus synchronizer.
REQ-004 RST  input  1: asynchronous, active-low reset.
REQ-005 sync_bus  input  DATA_WIDTH: synchronized byte, valid only in the cycle enable_pulse is high.
REQ-006 enable_pulse  input  1: one-cycle strobe that qualifies sync_bus.
REQ-007 RF_WrEn  output  1: one-cycle register-file write strobe.
REQ-008 RF_RdEn  output  1: one-cycle register-file read strobe.
REQ-009 RF_Address  output  ADDR_WIDTH: register-file address.
REQ-010 RF_WrData  output  DATA_WIDTH: register-file write data.
REQ-011 ALU_EN  output  1: one-cycle ALU start strobe.
REQ-012 ALU_FUN  output  4: ALU function code.
REQ-013 CLK_GATE_EN  output  1: ALU clock-gate enable.
REQ-014 busy  output  1: high while a frame is partially received.
REQ-015 cmd_err  output  1: one-cycle strobe for an unknown command byte.

Function
REQ-016 Only bytes with enable_pulse high are consumed; every pulse is accepted, back-to-back pulses included.
REQ-017 The frame formats are:
  - 0xAA: write, followed by addr, then data.
  - 0xBB: read, followed by addr.
  - 0xCC: ALU with operands, followed by A, B, FUN.
  - 0xDD: ALU without operands, followed by FUN.
REQ-018 The FSM states are IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN.
  - IDLE goes to WR_ADDR on 0xAA, RD_ADDR on 0xBB, OP_A on 0xCC, ALU_FUN on 0xDD.
  - A legal final byte returns the FSM to IDLE.
REQ-019 The address byte is truncated to its low ADDR_WIDTH bits and held in an internal address register.
REQ-020 The WR_DATA byte produces, in the next cycle: RF_WrEn=1, RF_Address=stored addr, RF_WrData=byte.
REQ-021 The RD_ADDR byte produces, in the next cycle: RF_RdEn=1, RF_Address=byte[ADDR_WIDTH-1:0].
REQ-022 The OP_A byte produces RF_WrEn to address 0 next cycle; the OP_B byte produces RF_WrEn to address 1 next cycle.
REQ-023 The ALU_FUN byte produces, in the next cycle: ALU_EN=1, ALU_FUN=byte[3:0].
REQ-024 CLK_GATE_EN is high in states OP_A, OP_B and ALU_FUN and in the cycle ALU_EN is high; it is low otherwise.
REQ-025 All outputs are registered; every strobe is exactly one cycle wide; data and address outputs hold their last value between strobes.
REQ-026 busy = (state != IDLE), registered with the state.
REQ-027 An unrecognized byte in IDLE produces cmd_err=1 for one cycle; the state stays IDLE.
REQ-028 In a non-IDLE state, any byte is treated as payload; there are no command escapes and no timeouts.
REQ-029 RF_WrEn and RF_RdEn are never high in the same cycle.

Reset
REQ-030 RST low asynchronously sets state=IDLE, clears all strobes, and clears RF_Address, RF_WrData, ALU_FUN, CLK_GATE_EN, busy and the address register.
REQ-031 A reset mid-frame discards the partial frame; the first pulse after release is decoded as a command byte.
REQ-032 Reset release is synchronous to CLK; no output toggles in the release cycle without enable_pulse.

Structure
REQ-033 The command codes (0xAA, 0xBB, 0xCC, 0xDD), the state encoding and the operand addresses 0 and 1 belong in the shared system package.
REQ-034 The block is a single module with no sub-modules.

Verification
REQ-035 Write frame: pulses AA, 05, 3C one cycle apart -> RF_WrEn=1 with RF_Address=5 and RF_WrData=0x3C, one cycle after the 3C pulse.
REQ-036 Read frame: pulses BB, 0A -> RF_RdEn=1 with RF_Address=0xA one cycle after the second pulse; busy is high between the two pulses.
REQ-037 ALU frame: pulses CC, 11, 22, 03 spaced 6 cycles apart ->
  - RF_WrEn at addr 0 with data 0x11, then at addr 1 with data 0x22;
  - ALU_EN with ALU_FUN=3;
  - CLK_GATE_EN high from the CC pulse through the ALU_EN cycle.
REQ-038 Pulses 7F, DD, 02 -> cmd_err one cycle after 7F, then ALU_EN with ALU_FUN=2; no RF strobes.
REQ-039 Pulses AA, 04, then RST low for 1 cycle, then BB, 04 -> no RF_WrEn at any time; RF_RdEn with RF_Address=4.
REQ-040 Address truncation: AA, F7, 99 -> RF_Address=7, RF_WrData=0x99.

Source files
------------

// File: rtl/cmd_decoder_pkg.sv
// Shared definitions for the command decoder: command codes, FSM state
// encoding and the fixed register-file addresses of the ALU operands.
package cmd_decoder_pkg;

   // Command bytes that open a frame
   localparam logic [7:0] CMD_WRITE   = 8'hAA;  // addr, data
   localparam logic [7:0] CMD_READ    = 8'hBB;  // addr
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;  // A, B, FUN
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;  // FUN

   // Register-file slots that hold the ALU operands
   localparam int unsigned OPA_ADDR = 32'd0;
   localparam int unsigned OPB_ADDR = 32'd1;

   // Decoder states; each non-idle state names the byte expected next
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_ADDR = 3'd1,
      ST_WR_DATA = 3'd2,
      ST_RD_ADDR = 3'd3,
      ST_OP_A    = 3'd4,
      ST_OP_B    = 3'd5,
      ST_ALU_FUN = 3'd6
   } state_e;

endpackage : cmd_decoder_pkg

// File: rtl/cmd_decoder.sv
// Command decoder: turns a stream of synchronized bytes into register-file
// and ALU control strobes. Each byte is qualified by enable_pulse; the first
// byte of a frame is the command, the rest is payload. All outputs are
// registered, so every effect appears in the cycle after its byte.
module cmd_decoder
   import cmd_decoder_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] sync_bus,
   input  logic                  enable_pulse,
   output logic                  RF_WrEn,
   output logic                  RF_RdEn,
   output logic [ADDR_WIDTH-1:0] RF_Address,
   output logic [DATA_WIDTH-1:0] RF_WrData,
   output logic                  ALU_EN,
   output logic [3:0]            ALU_FUN,
   output logic                  CLK_GATE_EN,
   output logic                  busy,
   output logic                  cmd_err
);

   state_e                  state_r, state_s;
   logic [ADDR_WIDTH-1:0]   addr_r, addr_s;

   logic                    wr_en_r, wr_en_s;
   logic                    rd_en_r, rd_en_s;
   logic [ADDR_WIDTH-1:0]   rf_addr_r, rf_addr_s;
   logic [DATA_WIDTH-1:0]   rf_data_r, rf_data_s;
   logic                    alu_en_r, alu_en_s;
   logic [3:0]              alu_fun_r, alu_fun_s;
   logic                    gate_r, gate_s;
   logic                    busy_r, busy_s;
   logic                    cmd_err_r, cmd_err_s;

   // Next-state and next-output decode for the byte presented this cycle
   always_comb begin
      state_s   = state_r;
      addr_s    = addr_r;
      wr_en_s   = 1'b0;
      rd_en_s   = 1'b0;
      rf_addr_s = rf_addr_r;
      rf_data_s = rf_data_r;
      alu_en_s  = 1'b0;
      alu_fun_s = alu_fun_r;
      cmd_err_s = 1'b0;

      if (enable_pulse) begin
         case (state_r)
            ST_IDLE: begin
               if (sync_bus == DATA_WIDTH'(CMD_WRITE)) begin
                  state_s = ST_WR_ADDR;
               end else if (sync_bus == DATA_WIDTH'(CMD_READ)) begin
                  state_s = ST_RD_ADDR;
               end else if (sync_bus == DATA_WIDTH'(CMD_ALU_OP)) begin
                  state_s = ST_OP_A;
               end else if (sync_bus == DATA_WIDTH'(CMD_ALU_NOP)) begin
                  state_s = ST_ALU_FUN;
               end else begin
                  // Unknown command: flag it and keep waiting for a command
                  cmd_err_s = 1'b1;
               end
            end
            ST_WR_ADDR: begin
               addr_s  = sync_bus[ADDR_WIDTH-1:0];
               state_s = ST_WR_DATA;
            end
            ST_WR_DATA: begin
               wr_en_s   = 1'b1;
               rf_addr_s = addr_r;
               rf_data_s = sync_bus;
               state_s   = ST_IDLE;
            end
            ST_RD_ADDR: begin
               rd_en_s   = 1'b1;
               rf_addr_s = sync_bus[ADDR_WIDTH-1:0];
               state_s   = ST_IDLE;
            end
            ST_OP_A: begin
               wr_en_s   = 1'b1;
               rf_addr_s = ADDR_WIDTH'(OPA_ADDR);
               rf_data_s = sync_bus;
               state_s   = ST_OP_B;
            end
            ST_OP_B: begin
               wr_en_s   = 1'b1;
               rf_addr_s = ADDR_WIDTH'(OPB_ADDR);
               rf_data_s = sync_bus;
               state_s   = ST_ALU_FUN;
            end
            ST_ALU_FUN: begin
               alu_en_s  = 1'b1;
               alu_fun_s = sync_bus[3:0];
               state_s   = ST_IDLE;
            end
            default: begin
               // Unreachable encodings fall back to idle
               state_s = ST_IDLE;
            end
         endcase
      end else begin
         state_s = state_r;
      end

      // Gate stays open while an ALU frame is in flight and for the start cycle
      gate_s = (state_s == ST_OP_A) || (state_s == ST_OP_B) ||
               (state_s == ST_ALU_FUN) || alu_en_s;
      busy_s = (state_s != ST_IDLE);
   end

   // State and captured address registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r <= ST_IDLE;
         addr_r  <= '0;
      end else begin
         state_r <= state_s;
         addr_r  <= addr_s;
      end
   end

   // Output registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_en_r   <= 1'b0;
         rd_en_r   <= 1'b0;
         rf_addr_r <= '0;
         rf_data_r <= '0;
         alu_en_r  <= 1'b0;
         alu_fun_r <= 4'd0;
         gate_r    <= 1'b0;
         busy_r    <= 1'b0;
         cmd_err_r <= 1'b0;
      end else begin
         wr_en_r   <= wr_en_s;
         rd_en_r   <= rd_en_s;
         rf_addr_r <= rf_addr_s;
         rf_data_r <= rf_data_s;
         alu_en_r  <= alu_en_s;
         alu_fun_r <= alu_fun_s;
         gate_r    <= gate_s;
         busy_r    <= busy_s;
         cmd_err_r <= cmd_err_s;
      end
   end

   assign RF_WrEn     = wr_en_r;
   assign RF_RdEn     = rd_en_r;
   assign RF_Address  = rf_addr_r;
   assign RF_WrData   = rf_data_r;
   assign ALU_EN      = alu_en_r;
   assign ALU_FUN     = alu_fun_r;
   assign CLK_GATE_EN = gate_r;
   assign busy        = busy_r;
   assign cmd_err     = cmd_err_r;

endmodule : cmd_decoder

// File: tb/tb_cmd_decoder.sv
// Directed testbench for cmd_decoder. Inputs change 1 time unit after the
// rising edge; a byte sent with send() has its registered effects visible
// right after the edge that consumed it.
module tb_cmd_decoder;

   localparam int DW = 8;
   localparam int AW = 4;

   logic          CLK;
   logic          RST;
   logic [DW-1:0] sync_bus;
   logic          enable_pulse;
   logic          RF_WrEn;
   logic          RF_RdEn;
   logic [AW-1:0] RF_Address;
   logic [DW-1:0] RF_WrData;
   logic          ALU_EN;
   logic [3:0]    ALU_FUN;
   logic          CLK_GATE_EN;
   logic          busy;
   logic          cmd_err;

   int checks = 0;
   int errors = 0;
   int both_strobes = 0;

   cmd_decoder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .sync_bus     (sync_bus),
      .enable_pulse (enable_pulse),
      .RF_WrEn      (RF_WrEn),
      .RF_RdEn      (RF_RdEn),
      .RF_Address   (RF_Address),
      .RF_WrData    (RF_WrData),
      .ALU_EN       (ALU_EN),
      .ALU_FUN      (ALU_FUN),
      .CLK_GATE_EN  (CLK_GATE_EN),
      .busy         (busy),
      .cmd_err      (cmd_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Read and write strobes must never coincide
   always @(negedge CLK) begin
      if (RF_WrEn && RF_RdEn) both_strobes++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic send(input logic [7:0] b);
      enable_pulse = 1'b1;
      sync_bus     = b;
      @(posedge CLK);
      #1;
      enable_pulse = 1'b0;
      sync_bus     = 8'h00;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   initial begin
      RST          = 1'b0;
      enable_pulse = 1'b0;
      sync_bus     = 8'h00;
      idle(2);

      // Reset state
      check("rst_wren",  {31'd0, RF_WrEn},     32'd0);
      check("rst_rden",  {31'd0, RF_RdEn},     32'd0);
      check("rst_addr",  {28'd0, RF_Address},  32'd0);
      check("rst_data",  {24'd0, RF_WrData},   32'd0);
      check("rst_fun",   {28'd0, ALU_FUN},     32'd0);
      check("rst_gate",  {31'd0, CLK_GATE_EN}, 32'd0);
      check("rst_busy",  {31'd0, busy},        32'd0);

      // Release with no pulse: nothing moves
      RST = 1'b1;
      idle(2);
      check("rel_busy",  {31'd0, busy},        32'd0);
      check("rel_err",   {31'd0, cmd_err},     32'd0);
      check("rel_alu",   {31'd0, ALU_EN},      32'd0);

      // Write frame AA 05 3C
      send(8'hAA);
      check("wr_busy1",  {31'd0, busy},        32'd1);
      check("wr_gate1",  {31'd0, CLK_GATE_EN}, 32'd0);
      send(8'h05);
      check("wr_busy2",  {31'd0, busy},        32'd1);
      check("wr_early",  {31'd0, RF_WrEn},     32'd0);
      send(8'h3C);
      check("wr_en",     {31'd0, RF_WrEn},     32'd1);
      check("wr_addr",   {28'd0, RF_Address},  32'd5);
      check("wr_data",   {24'd0, RF_WrData},   32'h3C);
      check("wr_busy3",  {31'd0, busy},        32'd0);
      idle(1);
      check("wr_pulse",  {31'd0, RF_WrEn},     32'd0);
      check("wr_hold_a", {28'd0, RF_Address},  32'd5);
      check("wr_hold_d", {24'd0, RF_WrData},   32'h3C);

      // Read frame BB 0A
      send(8'hBB);
      check("rd_busy",   {31'd0, busy},        32'd1);
      send(8'h0A);
      check("rd_en",     {31'd0, RF_RdEn},     32'd1);
      check("rd_wr",     {31'd0, RF_WrEn},     32'd0);
      check("rd_addr",   {28'd0, RF_Address},  32'hA);
      check("rd_busy2",  {31'd0, busy},        32'd0);
      idle(1);
      check("rd_pulse",  {31'd0, RF_RdEn},     32'd0);

      // ALU frame CC 11 22 03, six cycles apart
      send(8'hCC);
      check("alu_gate0", {31'd0, CLK_GATE_EN}, 32'd1);
      check("alu_busy0", {31'd0, busy},        32'd1);
      idle(5);
      check("alu_gate1", {31'd0, CLK_GATE_EN}, 32'd1);
      send(8'h11);
      check("opa_en",    {31'd0, RF_WrEn},     32'd1);
      check("opa_addr",  {28'd0, RF_Address},  32'd0);
      check("opa_data",  {24'd0, RF_WrData},   32'h11);
      idle(5);
      check("opa_pulse", {31'd0, RF_WrEn},     32'd0);
      check("alu_gate2", {31'd0, CLK_GATE_EN}, 32'd1);
      send(8'h22);
      check("opb_en",    {31'd0, RF_WrEn},     32'd1);
      check("opb_addr",  {28'd0, RF_Address},  32'd1);
      check("opb_data",  {24'd0, RF_WrData},   32'h22);
      idle(5);
      check("alu_gate3", {31'd0, CLK_GATE_EN}, 32'd1);
      send(8'h03);
      check("alu_en",    {31'd0, ALU_EN},      32'd1);
      check("alu_fun",   {28'd0, ALU_FUN},     32'd3);
      check("alu_gate4", {31'd0, CLK_GATE_EN}, 32'd1);
      check("alu_busy",  {31'd0, busy},        32'd0);
      idle(1);
      check("alu_pulse", {31'd0, ALU_EN},      32'd0);
      check("alu_gate5", {31'd0, CLK_GATE_EN}, 32'd0);
      check("alu_hold",  {28'd0, ALU_FUN},     32'd3);

      // Unknown command, then operand-less ALU frame
      send(8'h7F);
      check("err_on",    {31'd0, cmd_err},     32'd1);
      check("err_busy",  {31'd0, busy},        32'd0);
      send(8'hDD);
      check("err_off",   {31'd0, cmd_err},     32'd0);
      check("dd_busy",   {31'd0, busy},        32'd1);
      check("dd_gate",   {31'd0, CLK_GATE_EN}, 32'd1);
      send(8'h02);
      check("dd_alu",    {31'd0, ALU_EN},      32'd1);
      check("dd_fun",    {28'd0, ALU_FUN},     32'd2);
      check("dd_wr",     {31'd0, RF_WrEn},     32'd0);
      check("dd_rd",     {31'd0, RF_RdEn},     32'd0);

      // Reset mid-frame discards the partial write
      send(8'hAA);
      send(8'h04);
      RST = 1'b0;
      #1;
      check("mid_busy",  {31'd0, busy},        32'd0);
      check("mid_fun",   {28'd0, ALU_FUN},     32'd0);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      send(8'hBB);
      check("post_wr",   {31'd0, RF_WrEn},     32'd0);
      check("post_busy", {31'd0, busy},        32'd1);
      send(8'h04);
      check("post_rd",   {31'd0, RF_RdEn},     32'd1);
      check("post_wr2",  {31'd0, RF_WrEn},     32'd0);
      check("post_addr", {28'd0, RF_Address},  32'd4);

      // Address truncation
      send(8'hAA);
      send(8'hF7);
      send(8'h99);
      check("tr_en",     {31'd0, RF_WrEn},     32'd1);
      check("tr_addr",   {28'd0, RF_Address},  32'd7);
      check("tr_data",   {24'd0, RF_WrData},   32'h99);

      // Command codes inside a frame are plain payload
      send(8'hAA);
      send(8'hBB);
      check("pl_err",    {31'd0, cmd_err},     32'd0);
      send(8'hCC);
      check("pl_en",     {31'd0, RF_WrEn},     32'd1);
      check("pl_addr",   {28'd0, RF_Address},  32'hB);
      check("pl_data",   {24'd0, RF_WrData},   32'hCC);
      check("pl_gate",   {31'd0, CLK_GATE_EN}, 32'd0);
      idle(1);

      check("excl",      both_strobes,         32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_cmd_decoder
